// File: rtl/alu_unit.sv
// Execute-stage integer ALU: combinational 128-bit result and RFLAGS, registered mem_valid.
// Define ALU_MUL_EN to implement MUL (0x10) and IMUL (0x11); otherwise they decode as unknown.
module alu_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [7:0]   opcode,
    input  logic [63:0]  oprd1,
    input  logic [63:0]  oprd2,
    input  logic [63:0]  oprd3,
    output logic [127:0] result,
    output logic [63:0]  flags,
    output logic         mem_valid
);

    localparam logic [7:0] OpNop  = 8'h00;
    localparam logic [7:0] OpAdd  = 8'h01;
    localparam logic [7:0] OpSub  = 8'h02;
    localparam logic [7:0] OpAnd  = 8'h03;
    localparam logic [7:0] OpOr   = 8'h04;
    localparam logic [7:0] OpXor  = 8'h05;
    localparam logic [7:0] OpCmp  = 8'h06;
    localparam logic [7:0] OpTest = 8'h07;
    localparam logic [7:0] OpInc  = 8'h08;
    localparam logic [7:0] OpDec  = 8'h09;
    localparam logic [7:0] OpNeg  = 8'h0A;
    localparam logic [7:0] OpNot  = 8'h0B;
    localparam logic [7:0] OpShl  = 8'h0C;
    localparam logic [7:0] OpShr  = 8'h0D;
    localparam logic [7:0] OpSar  = 8'h0E;
    localparam logic [7:0] OpMov  = 8'h0F;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OpMul  = 8'h10;
    localparam logic [7:0] OpImul = 8'h11;
    logic [127:0] prod;
`endif
    localparam logic [7:0] OpAdc  = 8'h12;
    localparam logic [7:0] OpSbb  = 8'h13;

    logic [64:0] ext;
    logic [63:0] lo, hi, zsrc, fl;
    logic [5:0]  cnt, shl_idx;
    logic        wr_c, wr_o, wr_a, wr_zsp;
    logic        cf_v, of_v, af_v;
    logic        mem_valid_d, mem_valid_q;

    assign cnt     = oprd2[5:0];
    // Index of the last bit shifted out on a left shift by cnt (cnt != 0).
    assign shl_idx = 6'(7'd64 - {1'b0, cnt});

    always_comb begin
        ext    = '0;
        lo     = '0;
        hi     = '0;
        zsrc   = '0;
        wr_c   = 1'b0;
        wr_o   = 1'b0;
        wr_a   = 1'b0;
        wr_zsp = 1'b0;
        cf_v   = 1'b0;
        of_v   = 1'b0;
        af_v   = 1'b0;
`ifdef ALU_MUL_EN
        prod   = '0;
`endif
        case (opcode)
            OpNop: lo = oprd1;
            OpAdd, OpAdc: begin
                ext  = {1'b0, oprd1} + {1'b0, oprd2} + {64'd0, (opcode == OpAdc) && oprd3[0]};
                lo   = ext[63:0];
                zsrc = ext[63:0];
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
                cf_v = ext[64];
                of_v = (oprd1[63] == oprd2[63]) && (ext[63] != oprd1[63]);
                af_v = oprd1[4] ^ oprd2[4] ^ ext[4];
            end
            OpSub, OpCmp, OpSbb: begin
                ext  = {1'b0, oprd1} - {1'b0, oprd2} - {64'd0, (opcode == OpSbb) && oprd3[0]};
                // CMP keeps the destination but reports the flags of the difference.
                lo   = (opcode == OpCmp) ? oprd1 : ext[63:0];
                zsrc = ext[63:0];
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
                cf_v = ext[64];
                of_v = (oprd1[63] != oprd2[63]) && (ext[63] != oprd1[63]);
                af_v = oprd1[4] ^ oprd2[4] ^ ext[4];
            end
            OpAnd, OpTest: begin
                lo   = (opcode == OpTest) ? oprd1 : (oprd1 & oprd2);
                zsrc = oprd1 & oprd2;
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
            end
            OpOr: begin
                lo   = oprd1 | oprd2;
                zsrc = lo;
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
            end
            OpXor: begin
                lo   = oprd1 ^ oprd2;
                zsrc = lo;
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
            end
            OpInc: begin
                ext  = {1'b0, oprd1} + 65'd1;
                lo   = ext[63:0];
                zsrc = ext[63:0];
                {wr_o, wr_a, wr_zsp} = '1;
                of_v = ~oprd1[63] & ext[63];
                af_v = oprd1[4] ^ ext[4];
            end
            OpDec: begin
                ext  = {1'b0, oprd1} - 65'd1;
                lo   = ext[63:0];
                zsrc = ext[63:0];
                {wr_o, wr_a, wr_zsp} = '1;
                of_v = oprd1[63] & ~ext[63];
                af_v = oprd1[4] ^ ext[4];
            end
            OpNeg: begin
                ext  = 65'd0 - {1'b0, oprd1};
                lo   = ext[63:0];
                zsrc = ext[63:0];
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
                cf_v = |oprd1;
                of_v = (oprd1 == 64'h8000_0000_0000_0000);
                af_v = oprd1[4] ^ ext[4];
            end
            OpNot: lo = ~oprd1;
            OpShl: begin
                lo = oprd1 << cnt;
                if (cnt != 6'd0) begin
                    zsrc = lo;
                    {wr_c, wr_o, wr_a, wr_zsp} = '1;
                    cf_v = oprd1[shl_idx];
                    of_v = (cnt == 6'd1) && (lo[63] ^ oprd1[shl_idx]);
                end
            end
            OpShr: begin
                lo = oprd1 >> cnt;
                if (cnt != 6'd0) begin
                    zsrc = lo;
                    {wr_c, wr_o, wr_a, wr_zsp} = '1;
                    cf_v = oprd1[cnt - 6'd1];
                    of_v = (cnt == 6'd1) && oprd1[63];
                end
            end
            OpSar: begin
                lo = $unsigned($signed(oprd1) >>> cnt);
                if (cnt != 6'd0) begin
                    zsrc = lo;
                    {wr_c, wr_o, wr_a, wr_zsp} = '1;
                    cf_v = oprd1[cnt - 6'd1];
                end
            end
            OpMov: lo = oprd2;
`ifdef ALU_MUL_EN
            OpMul: begin
                prod = {64'd0, oprd1} * {64'd0, oprd2};
                lo   = prod[63:0];
                hi   = prod[127:64];
                zsrc = prod[63:0];
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
                cf_v = |prod[127:64];
                of_v = |prod[127:64];
            end
            OpImul: begin
                // Low 128 bits of the sign-extended product equal the signed product.
                prod = {{64{oprd1[63]}}, oprd1} * {{64{oprd2[63]}}, oprd2};
                lo   = prod[63:0];
                hi   = prod[127:64];
                zsrc = prod[63:0];
                {wr_c, wr_o, wr_a, wr_zsp} = '1;
                cf_v = prod[127:64] != {64{prod[63]}};
                of_v = prod[127:64] != {64{prod[63]}};
            end
`endif
            default: ;
        endcase

        fl    = oprd3;
        fl[1] = 1'b1;
        if (wr_c) fl[0]  = cf_v;
        if (wr_o) fl[11] = of_v;
        if (wr_a) fl[4]  = af_v;
        if (wr_zsp) begin
            fl[6] = (zsrc == 64'd0);
            fl[7] = zsrc[63];
            fl[2] = ~^zsrc[7:0];
        end

        if (enable) begin
            result = {hi, lo};
            flags  = fl;
        end else begin
            result = '0;
            flags  = '0;
        end
    end

    always_comb mem_valid_d = enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_valid_q <= 1'b0;
        else       mem_valid_q <= mem_valid_d;
    end

    assign mem_valid = mem_valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: a driver queues expected responses, a monitor checks them.
module tb_alu_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [7:0]   opcode;
    logic [63:0]  oprd1, oprd2, oprd3;
    logic [127:0] result;
    logic [63:0]  flags;
    logic         mem_valid;

    alu_unit dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .opcode    (opcode),
        .oprd1     (oprd1),
        .oprd2     (oprd2),
        .oprd3     (oprd3),
        .result    (result),
        .flags     (flags),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] r;
        logic [63:0]  f;
        logic         mv;
        logic [7:0]   op;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic last_en = 1'b0;

    // Add or subtract with carry-in; flags derived from wide-integer range checks.
    function automatic void arith(input logic [63:0] a, input logic [63:0] b, input logic ci,
                                  input logic sub, output logic [63:0] r, output logic c,
                                  output logic o, output logic ac);
        logic signed [129:0] sa, sb_, sr, smax, smin;
        logic [129:0] ua, ub, ur;
        int na, nb;
        smax = 130'sh7FFF_FFFF_FFFF_FFFF;
        smin = -smax - 130'sd1;
        sa = {{66{a[63]}}, a};
        sb_ = {{66{b[63]}}, b};
        ua = {66'd0, a};
        ub = {66'd0, b};
        na = int'(a[3:0]);
        nb = int'(b[3:0]);
        if (sub) begin
            ur = ua - ub - {129'd0, ci};
            sr = sa - sb_ - $signed({129'd0, ci});
            c  = (ub + {129'd0, ci}) > ua;
            ac = na < nb + int'(ci);
        end else begin
            ur = ua + ub + {129'd0, ci};
            sr = sa + sb_ + $signed({129'd0, ci});
            c  = ur > 130'hFFFF_FFFF_FFFF_FFFF;
            ac = na + nb + int'(ci) > 15;
        end
        o = (sr > smax) || (sr < smin);
        r = ur[63:0];
    endfunction

`ifdef ALU_MUL_EN
    function automatic void mul_model(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                                      output logic [127:0] p, output logic ov);
        logic [63:0] ma, mb;
        logic signed [127:0] sp, lim;
        lim = 128'sh7FFF_FFFF_FFFF_FFFF;
        ma = (sgn && a[63]) ? (~a + 64'd1) : a;
        mb = (sgn && b[63]) ? (~b + 64'd1) : b;
        p  = {64'd0, ma} * {64'd0, mb};
        if (sgn && (a[63] ^ b[63])) p = ~p + 128'd1;
        sp = $signed(p);
        if (sgn) ov = (sp > lim) || (sp < -lim - 128'sd1);
        else     ov = p > 128'hFFFF_FFFF_FFFF_FFFF;
    endfunction
`endif

    function automatic void model(input logic en, input logic [7:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] f,
                                  output logic [127:0] r, output logic [63:0] fl);
        logic [63:0] lo, hi, zs, v;
        logic c, o, ac, cs, os, as, zset;
        int n;
`ifdef ALU_MUL_EN
        logic [127:0] p;
`endif
        lo = '0; hi = '0; zs = '0; v = '0;
        c = 0; o = 0; ac = 0; cs = 0; os = 0; as = 0; zset = 0;
        n = int'(b[5:0]);
        case (op)
            8'h00: lo = a;
            8'h01, 8'h12, 8'h02, 8'h13: begin
                arith(a, b, (op >= 8'h12) ? f[0] : 1'b0, (op == 8'h02) || (op == 8'h13),
                      lo, c, o, ac);
                zs = lo; {cs, os, as, zset} = '1;
            end
            8'h06: begin
                arith(a, b, 1'b0, 1'b1, zs, c, o, ac);
                lo = a; {cs, os, as, zset} = '1;
            end
            8'h03: begin lo = a & b; zs = lo; {cs, os, as, zset} = '1; end
            8'h04: begin lo = a | b; zs = lo; {cs, os, as, zset} = '1; end
            8'h05: begin lo = a ^ b; zs = lo; {cs, os, as, zset} = '1; end
            8'h07: begin lo = a; zs = a & b; {cs, os, as, zset} = '1; end
            8'h08, 8'h09: begin
                arith(a, 64'd1, 1'b0, op == 8'h09, lo, c, o, ac);
                zs = lo; {os, as, zset} = '1;
            end
            8'h0A: begin
                arith(64'd0, a, 1'b0, 1'b1, lo, c, o, ac);
                zs = lo; {cs, os, as, zset} = '1;
            end
            8'h0B: lo = ~a;
            8'h0C, 8'h0D, 8'h0E: begin
                v = a;
                for (int i = 0; i < n; i++) begin
                    if (op == 8'h0C) begin c = v[63]; v = {v[62:0], 1'b0}; end
                    else if (op == 8'h0D) begin c = v[0]; v = {1'b0, v[63:1]}; end
                    else begin c = v[0]; v = {v[63], v[63:1]}; end
                end
                lo = v;
                if (n != 0) begin
                    zs = v; {cs, os, as, zset} = '1; ac = 0;
                    if (n == 1 && op == 8'h0C) o = v[63] ^ c;
                    else if (n == 1 && op == 8'h0D) o = a[63];
                    else o = 0;
                end
            end
            8'h0F: lo = b;
`ifdef ALU_MUL_EN
            8'h10, 8'h11: begin
                mul_model(op == 8'h11, a, b, p, o);
                {hi, lo} = p; zs = lo; c = o; {cs, os, as, zset} = '1;
            end
`endif
            default: ;
        endcase
        fl = f;
        fl[1] = 1'b1;
        if (cs) fl[0] = c;
        if (os) fl[11] = o;
        if (as) fl[4] = ac;
        if (zset) begin
            fl[6] = (zs == 64'd0);
            fl[7] = zs[63];
            fl[2] = ($countones(zs[7:0]) % 2) == 0;
        end
        if (en) r = {hi, lo};
        else begin r = '0; fl = '0; end
    endfunction

    task automatic drive(input logic en, input logic [7:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] f, input logic use_k,
                         input logic [127:0] kr, input logic [63:0] kf);
        exp_t e;
        logic [127:0] r;
        logic [63:0] fl;
        @(posedge clk); #1;
        enable = en; opcode = op; oprd1 = a; oprd2 = b; oprd3 = f;
        model(en, op, a, b, f, r, fl);
        e.r  = use_k ? kr : r;
        e.f  = use_k ? kf : fl;
        e.mv = last_en;
        e.op = op;
        last_en = en;
        sb.push_back(e);
    endtask

    task automatic check_mv(input string name, input logic want);
        n_vec++;
        if (mem_valid !== want) begin
            n_err++;
            $display("FAIL %s: mem_valid got %b required %b", name, mem_valid, want);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            5: return 64'($urandom_range(0, 70));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Monitor: combinational outputs are presented each cycle a vector is on the bus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (result !== e.r) begin
                    n_err++;
                    $display("FAIL result op=%h: got %h required %h", e.op, result, e.r);
                end
                if (flags !== e.f) begin
                    n_err++;
                    $display("FAIL flags op=%h: got %h required %h", e.op, flags, e.f);
                end
                if (mem_valid !== e.mv) begin
                    n_err++;
                    $display("FAIL mem_valid op=%h: got %b required %b", e.op, mem_valid, e.mv);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] op;
        reset = 1'b1; enable = 1'b1; opcode = '0; oprd1 = '0; oprd2 = '0; oprd3 = '0;
        #1 check_mv("reset_async", 1'b0);
        @(posedge clk); #1 check_mv("reset_held", 1'b0);
        enable = 1'b0;
        @(negedge clk) reset = 1'b0;
        last_en = 1'b0;

        drive(1, 8'h01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1,
              128'h8000_0000_0000_0000, 64'h896);
        drive(1, 8'h02, 64'd0, 64'd1, 64'd0, 1, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h97);
`ifdef ALU_MUL_EN
        drive(1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1,
              128'h1_FFFF_FFFF_FFFF_FFFE, 64'h883);
`else
        drive(1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1, 128'd0, 64'h2);
`endif
        drive(1, 8'h0C, 64'h8000_0000_0000_0001, 64'd0, 64'h41, 1,
              {64'd0, 64'h8000_0000_0000_0001}, 64'h43);
        drive(1, 8'h0C, 64'h8000_0000_0000_0001, 64'd1, 64'h41, 1, 128'd2, 64'h803);
        drive(0, 8'h01, 64'h1234, 64'h5678, 64'hFFF, 1, 128'd0, 64'd0);
        drive(1, 8'hFF, 64'h1234, 64'h5678, 64'h800, 1, 128'd0, 64'h802);
        drive(0, 8'h00, 64'd0, 64'd0, 64'd0, 1, 128'd0, 64'd0);
        drive(1, 8'h0A, 64'd0, 64'd0, 64'd0, 1, 128'd0, 64'h46);
        drive(1, 8'h0A, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 1,
              {64'd0, 64'h8000_0000_0000_0000}, 64'h887);
        drive(1, 8'h0E, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1,
              {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h86);
        drive(1, 8'h08, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 1, 128'd0, 64'h57);

        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 19));
            drive($urandom_range(0, 9) != 0, op, rnd64(), rnd64(), {$urandom(), $urandom()},
                  0, 128'd0, 64'd0);
        end

        // Single enable pulse: mem_valid high for exactly the following cycle.
        drive(0, 8'h00, 64'd0, 64'd0, 64'd0, 0, 128'd0, 64'd0);
        drive(1, 8'h01, 64'd3, 64'd4, 64'd0, 0, 128'd0, 64'd0);
        drive(0, 8'h00, 64'd0, 64'd0, 64'd0, 0, 128'd0, 64'd0);
        drive(0, 8'h00, 64'd0, 64'd0, 64'd0, 0, 128'd0, 64'd0);

        // Reset asserted between edges with enable still high.
        drive(1, 8'h05, 64'd6, 64'd3, 64'd0, 0, 128'd0, 64'd0);
        @(posedge clk); #2;
        check_mv("pre_reset", 1'b1);
        reset = 1'b1;
        #1 check_mv("reset_midcycle", 1'b0);
        @(posedge clk); #1 check_mv("reset_hold_en", 1'b0);
        enable = 1'b0;
        last_en = 1'b0;
        #1 reset = 1'b0;
        drive(1, 8'h0F, 64'd0, 64'd9, 64'd0, 0, 128'd0, 64'd0);
        drive(0, 8'h00, 64'd0, 64'd0, 64'd0, 0, 128'd0, 64'd0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left required 0", sb.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
